// File: rtl/debug_mem_access_master_pkg.sv
// Shared definitions for the debug access bus initiator: bus bit positions,
// FSM state encoding and a helper that assembles the 56-bit access word.
package debug_access_pkg;

    localparam int DA_BUS_W    = 56;
    localparam int DA_EN       = 55;
    localparam int DA_WE       = 49;
    localparam int DA_TRIG     = 48;
    localparam int DA_ADDR_LSB = 32;
    localparam int DA_ADDR_MSB = 47;
    localparam int DA_DATA_MSB = 31;
    localparam int DA_ADDR_W   = DA_ADDR_MSB - DA_ADDR_LSB + 1;
    localparam int DA_DATA_W   = DA_DATA_MSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TRIG,
        SAMPLE,
        RELEASE,
        RESP
    } da_state_e;

    // Assemble an access word; bits [54:50] are never set.
    function automatic logic [DA_BUS_W-1:0] da_pack(
        input logic                 en,
        input logic                 we,
        input logic                 trig,
        input logic [DA_ADDR_W-1:0] addr,
        input logic [DA_DATA_W-1:0] data
    );
        logic [DA_BUS_W-1:0] b;
        b                          = '0;
        b[DA_EN]                   = en;
        b[DA_WE]                   = we;
        b[DA_TRIG]                 = trig;
        b[DA_ADDR_MSB:DA_ADDR_LSB] = addr;
        b[DA_DATA_MSB:0]           = data;
        return b;
    endfunction

endpackage

// File: rtl/debug_mem_access_master_if.sv
// Command, response and access-bus signals between the debug host side,
// the initiator and the SRAM wrapper.
interface debug_mem_access_master_if #(
    parameter int ADDR_WIDTH = 16
);
    import debug_access_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_wdata;
    logic [7:0]            cmd_len;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  rsp_err;

    logic [DA_BUS_W-1:0]   access_bits_out;
    logic [DA_BUS_W-1:0]   access_bits_in;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_addr, rsp_err,
        input  rsp_ready,
        output access_bits_out,
        input  access_bits_in
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_len,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_addr, rsp_err,
        output rsp_ready,
        input  access_bits_out,
        output access_bits_in
    );

endinterface

// File: rtl/debug_mem_access_master.sv
// Debug access bus initiator. Takes one host command at a time, sequences
// enable / setup / trigger / release on the 56-bit access bus, captures the
// returned word and offers it on the response port. Every output is a flop.
// Optional feature macro: DBG_ACCESS_BURST_EN (multi-beat commands using cmd_len).
module debug_mem_access_master
    import debug_access_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int TRIG_CYCLES = 4,
    parameter int REL_CYCLES  = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    output logic                      busy,
    debug_mem_access_master_if.master bus
);

    // One counter serves both TRIG and RELEASE dwell times.
    localparam int CNT_MAX = (TRIG_CYCLES > REL_CYCLES) ? TRIG_CYCLES : REL_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    da_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DA_BUS_W-1:0]   bus_q, bus_d;
    logic                  en_d, trig_d;
    logic                  more_beats;

    // Responder bits above the address echo carry nothing this block uses.
    logic unused_in;
    assign unused_in = ^bus.access_bits_in[DA_BUS_W-1:DA_ADDR_MSB+1];

`ifdef DBG_ACCESS_BURST_EN
    // Beats still to run for the current command, including the one in flight.
    logic [7:0] beats_q, beats_d;
    assign more_beats = (beats_q > 8'd1);

    // Beat counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) beats_q <= '0;
        else         beats_q <= beats_d;
    end

    // Load on accept (zero length means one beat), step down per handshake.
    always_comb begin
        beats_d = beats_q;
        if (state_q == IDLE && bus.cmd_valid && cmd_ready_q)
            beats_d = (bus.cmd_len == 8'd0) ? 8'd1 : bus.cmd_len;
        else if (state_q == RESP && bus.rsp_ready && rsp_valid_q && more_beats)
            beats_d = beats_q - 8'd1;
    end
`else
    logic unused_len;
    assign unused_len = ^bus.cmd_len;
    assign more_beats = 1'b0;
`endif

    // State, counter, latched command and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            bus_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            bus_q       <= bus_d;
        end
    end

    // Next state, command latching, sampling, and next values of the output flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    write_d = bus.cmd_write;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(TRIG_CYCLES - 1);
                state_d = TRIG;
            end
            TRIG: begin
                if (cnt_q == '0) state_d = SAMPLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            SAMPLE: begin
                // Writes echo the data that was driven; reads take the responder word.
                rdata_d = write_q ? wdata_q : bus.access_bits_in[DA_DATA_MSB:0];
                err_d   = (bus.access_bits_in[DA_ADDR_MSB:DA_ADDR_LSB] != DA_ADDR_W'(addr_q));
                cnt_d   = CNT_W'(REL_CYCLES - 1);
                state_d = RELEASE;
            end
            RELEASE: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RESP: begin
                if (bus.rsp_ready && rsp_valid_q) begin
                    if (more_beats) begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the state being entered so they register with it.
        en_d        = (state_d == SETUP) || (state_d == TRIG) ||
                      (state_d == SAMPLE) || (state_d == RELEASE);
        trig_d      = (state_d == TRIG);
        bus_d       = en_d ? da_pack(1'b1, write_d, trig_d, DA_ADDR_W'(addr_d), wdata_d)
                           : '0;
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    assign bus.cmd_ready       = cmd_ready_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_rdata       = rdata_q;
    assign bus.rsp_addr        = addr_q;
    assign bus.rsp_err         = err_q;
    assign bus.access_bits_out = bus_q;
    assign busy                = busy_q;

endmodule
